// File: rtl/prefetch_queue_ctrl_pkg.sv
// Shared definitions for the t8086 instruction prefetch controller:
// FSM encodings, reset defaults, queue entry layout and address helper.
package prefetch_queue_ctrl_pkg;

    typedef enum logic [2:0] {
        PQ_RESET,
        PQ_FETCH,
        PQ_FULL,
        PQ_HOLD,
        PQ_FLUSH
    } pq_state_t;

    localparam logic [15:0] PQ_RESET_CS = 16'hFFFF;
    localparam logic [15:0] PQ_RESET_IP = 16'h0000;

    typedef struct packed {
        logic [15:0] ip;
        logic [7:0]  data;
    } pq_entry_t;

    // Real-mode segment:offset translation, wrapping at 1 MiB.
    function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
        return {seg, 4'b0000} + {4'b0000, off};
    endfunction

endpackage

// File: rtl/pq_fifo.sv
// Circular buffer of {ip,byte} entries for the prefetch queue.
// Clear wins over push/pop; pointers wrap mod DEPTH.
import prefetch_queue_ctrl_pkg::*;

module pq_fifo #(
    parameter int DEPTH = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  pq_entry_t  push_data,
    input  logic       pop,
    output pq_entry_t  head,
    output logic [3:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pq_entry_t         mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop & (count != 4'd0) & ~clear;
    assign do_push = push & ((count < 4'(DEPTH)) | do_pop) & ~clear;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 4'd0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + {3'b000, do_push} - {3'b000, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/prefetch_queue_ctrl.sv
// Instruction prefetch controller: issues byte reads from ROM into a small
// queue, tracks per-byte IP, and handles branch flush and bus hold.
import prefetch_queue_ctrl_pkg::*;

module prefetch_queue_ctrl #(
    parameter int          DEPTH    = 6,
    parameter logic [15:0] RESET_CS = PQ_RESET_CS,
    parameter logic [15:0] RESET_IP = PQ_RESET_IP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic [15:0] flush_cs,
    input  logic [15:0] flush_ip,
    input  logic        q_pop,
    output logic        q_valid,
    output logic [7:0]  q_data,
    output logic [15:0] q_ip,
    output logic [3:0]  q_count,
    output logic        rom_en,
    output logic [19:0] rom_addr,
    input  logic [7:0]  rom_data
);

    pq_state_t   state, state_nxt;
    logic [15:0] cs_q;
    logic [15:0] fetch_ip_q;
    logic [15:0] head_ip_q;
    logic [15:0] issue_ip_q;
    logic        inflight_q;
    logic        discard_q;
    logic        inflight_eff;
    logic        push_eff;
    logic        pop_eff;
    logic [4:0]  occ_now;
    logic [4:0]  occ_after;
    logic        has_room;
    pq_entry_t   head;

    assign q_valid      = (q_count != 4'd0);
    assign inflight_eff = inflight_q & ~discard_q;
    assign push_eff     = inflight_eff & ~flush;
    assign pop_eff      = q_pop & q_valid & ~flush;

    // Occupancy counts the byte on its way back and credits this cycle's pop,
    // so a pop at full restarts issue in the same cycle.
    assign occ_now   = {1'b0, q_count} + {4'b0, inflight_eff} - {4'b0, pop_eff};
    assign has_room  = occ_now < 5'(DEPTH);
    assign occ_after = occ_now + {4'b0, rom_en};

    assign rom_en   = (state != PQ_RESET) & ~hold & ~flush & has_room;
    assign rom_addr = phys_addr(cs_q, fetch_ip_q);

    assign q_data = q_valid ? head.data : 8'h00;
    assign q_ip   = q_valid ? head.ip   : head_ip_q;

    pq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push_eff),
        .push_data ('{ip: issue_ip_q, data: rom_data}),
        .pop       (pop_eff),
        .head      (head),
        .count     (q_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PQ_RESET;
            cs_q       <= RESET_CS;
            fetch_ip_q <= RESET_IP;
            head_ip_q  <= RESET_IP;
            issue_ip_q <= RESET_IP;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                cs_q       <= flush_cs;
                fetch_ip_q <= flush_ip;
                head_ip_q  <= flush_ip;
                inflight_q <= 1'b0;
                discard_q  <= 1'b1;
            end else begin
                inflight_q <= rom_en;
                discard_q  <= 1'b0;
                if (rom_en) begin
                    issue_ip_q <= fetch_ip_q;
                    fetch_ip_q <= fetch_ip_q + 16'd1;
                end
                if (pop_eff) head_ip_q <= head.ip + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush)                          state_nxt = PQ_FLUSH;
        else if (state == PQ_RESET)         state_nxt = PQ_FETCH;
        else if (hold)                      state_nxt = PQ_HOLD;
        else if (occ_after >= 5'(DEPTH))    state_nxt = PQ_FULL;
        else                                state_nxt = PQ_FETCH;
    end

endmodule

// File: tb/tb_prefetch_queue_ctrl.sv
// Scoreboard bench for prefetch_queue_ctrl: expected fetch addresses and
// popped {ip,byte} pairs are queued by stimulus and checked by a monitor.
module tb_prefetch_queue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] flush_cs = 16'h0;
    logic [15:0] flush_ip = 16'h0;
    logic        q_pop = 1'b0;
    logic        q_valid;
    logic [7:0]  q_data;
    logic [15:0] q_ip;
    logic [3:0]  q_count;
    logic        rom_en;
    logic [19:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] exp_addr[$];
    logic [23:0] exp_byte[$];

    always #5 clk = ~clk;

    prefetch_queue_ctrl #(.DEPTH(6)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .flush_cs(flush_cs), .flush_ip(flush_ip), .q_pop(q_pop),
        .q_valid(q_valid), .q_data(q_data), .q_ip(q_ip), .q_count(q_count),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    // ROM contents: a cheap address hash so every location is distinguishable.
    function automatic logic [7:0] rom_fn(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h0};
    endfunction

    always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every fetch and every accepted pop is checked against the queues.
    always @(negedge clk) begin
        if (rom_en) begin
            if (exp_addr.size() == 0) begin
                n_checks++;
                $display("FAIL extra_fetch: got addr %05h expected no fetch", rom_addr);
            end else check("rom_addr", 32'(rom_addr), 32'(exp_addr.pop_front()));
        end
        if (q_pop && q_valid && !flush && rst) begin
            if (exp_byte.size() == 0) begin
                n_checks++;
                $display("FAIL extra_pop: got %04h:%02h expected none", q_ip, q_data);
            end else check("pop_byte", 32'({q_ip, q_data}), 32'(exp_byte.pop_front()));
        end
    end

    task automatic check_reset_vals();
        check("rst_rom_en",  32'(rom_en),   32'h0);
        check("rst_addr",    32'(rom_addr), 32'hFFFF0);
        check("rst_q_valid", 32'(q_valid),  32'h0);
        check("rst_q_data",  32'(q_data),   32'h0);
        check("rst_q_ip",    32'(q_ip),     32'h0);
        check("rst_q_count", 32'(q_count),  32'h0);
    endtask

    initial begin
        // Reset state, then fill from FFFF0 with no pops
        repeat (2) cyc();
        @(negedge clk) check_reset_vals();
        for (int i = 0; i < 6; i++) exp_addr.push_back(20'hFFFF0 + 20'(i));
        cyc(); rst = 1'b1;
        repeat (12) cyc();
        @(negedge clk);
        check("fill_count",  32'(q_count), 32'd6);
        check("fill_rom_en", 32'(rom_en),  32'd0);
        check("fill_data",   32'(q_data),  32'(rom_fn(20'hFFFF0)));
        check("fill_ip",     32'(q_ip),    32'h0);

        // Single pop at full: refill issues in the pop cycle
        exp_byte.push_back({16'h0000, rom_fn(20'hFFFF0)});
        exp_addr.push_back(20'hFFFF6);
        cyc(); q_pop = 1'b1;
        @(negedge clk) check("refill_issue", 32'(rom_en), 32'd1);
        cyc(); q_pop = 1'b0;
        @(negedge clk);
        check("pop_ip",    32'(q_ip),    32'h1);
        check("pop_count", 32'(q_count), 32'd5);
        cyc();
        @(negedge clk) check("refill_count", 32'(q_count), 32'd6);

        // Flush to 1234:FFFE with a fetch in flight; IP wraps inside the segment
        exp_byte.push_back({16'h0001, rom_fn(20'hFFFF1)});
        exp_addr.push_back(20'hFFFF7);
        cyc(); q_pop = 1'b1;
        cyc(); q_pop = 1'b0; flush = 1'b1; flush_cs = 16'h1234; flush_ip = 16'hFFFE;
        @(negedge clk) check("flush_no_issue", 32'(rom_en), 32'd0);
        exp_addr.push_back(20'h2233E);
        exp_addr.push_back(20'h2233F);
        for (int i = 0; i < 4; i++) exp_addr.push_back(20'h12340 + 20'(i));
        cyc(); flush = 1'b0;
        @(negedge clk);
        check("flush_q_valid", 32'(q_valid), 32'd0);
        check("flush_count",   32'(q_count), 32'd0);
        check("flush_refetch", 32'(rom_en),  32'd1);
        repeat (9) cyc();
        @(negedge clk);
        check("wrap_count", 32'(q_count), 32'd6);
        check("wrap_ip",    32'(q_ip),    32'hFFFE);
        check("wrap_data",  32'(q_data),  32'(rom_fn(20'h2233E)));
        exp_byte.push_back({16'hFFFE, rom_fn(20'h2233E)});
        exp_byte.push_back({16'hFFFF, rom_fn(20'h2233F)});
        exp_byte.push_back({16'h0000, rom_fn(20'h12340)});
        for (int i = 4; i < 7; i++) exp_addr.push_back(20'h12340 + 20'(i));
        cyc(); q_pop = 1'b1;
        repeat (2) cyc();
        cyc(); q_pop = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        check("wrap_refill_count", 32'(q_count), 32'd6);
        check("wrap_refill_ip",    32'(q_ip),    32'h0001);

        // Pop, returning byte and flush all in one cycle
        exp_byte.push_back({16'h0001, rom_fn(20'h12341)});
        exp_addr.push_back(20'h12347);
        cyc(); q_pop = 1'b1;
        cyc(); flush = 1'b1; flush_cs = 16'h0100; flush_ip = 16'h0020;
        @(negedge clk);
        check("pf_valid_before", 32'(q_valid), 32'd1);
        check("pf_no_issue",     32'(rom_en),  32'd0);
        for (int i = 0; i < 6; i++) exp_addr.push_back(20'h01020 + 20'(i));
        cyc(); q_pop = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("pf_count",   32'(q_count), 32'd0);
        check("pf_q_valid", 32'(q_valid), 32'd0);
        check("pf_q_data",  32'(q_data),  32'd0);
        check("pf_q_ip",    32'(q_ip),    32'h0020);
        repeat (9) cyc();
        @(negedge clk);
        check("pf_fill_count", 32'(q_count), 32'd6);
        check("pf_fill_ip",    32'(q_ip),    32'h0020);
        check("pf_fill_data",  32'(q_data),  32'(rom_fn(20'h01020)));

        // Hold for three cycles mid-stream
        cyc(); flush = 1'b1; flush_cs = 16'h0200; flush_ip = 16'h0000;
        for (int i = 0; i < 6; i++) exp_addr.push_back(20'h02000 + 20'(i));
        cyc(); flush = 1'b0;
        cyc();
        cyc(); hold = 1'b1;
        @(negedge clk);
        check("hold_rom_en0", 32'(rom_en),  32'd0);
        check("hold_count0",  32'(q_count), 32'd1);
        cyc();
        @(negedge clk);
        check("hold_rom_en1", 32'(rom_en),  32'd0);
        check("hold_landed",  32'(q_count), 32'd2);
        cyc();
        @(negedge clk);
        check("hold_rom_en2", 32'(rom_en),  32'd0);
        check("hold_count2",  32'(q_count), 32'd2);
        cyc(); hold = 1'b0;
        @(negedge clk) check("hold_resume", 32'(rom_en), 32'd1);
        repeat (8) cyc();
        @(negedge clk) check("hold_fill_count", 32'(q_count), 32'd6);
        for (int i = 0; i < 6; i++) exp_byte.push_back({16'(i), rom_fn(20'h02000 + 20'(i))});
        cyc(); hold = 1'b1; q_pop = 1'b1;
        repeat (5) cyc();
        cyc(); q_pop = 1'b0;
        @(negedge clk);
        check("drain_valid", 32'(q_valid), 32'd0);
        check("drain_count", 32'(q_count), 32'd0);
        check("drain_ip",    32'(q_ip),    32'h0006);

        // Pop while empty is ignored
        cyc(); q_pop = 1'b1;
        @(negedge clk);
        check("empty_pop_count", 32'(q_count), 32'd0);
        check("empty_pop_data",  32'(q_data),  32'd0);
        cyc(); q_pop = 1'b0;
        @(negedge clk);
        check("empty_pop_ip",    32'(q_ip),    32'h0006);
        check("empty_pop_valid", 32'(q_valid), 32'd0);

        // Reset asserted with a fetch in flight
        exp_addr.push_back(20'h02006);
        cyc(); hold = 1'b0;
        cyc(); rst = 1'b0;
        @(negedge clk) check_reset_vals();
        for (int i = 0; i < 6; i++) exp_addr.push_back(20'hFFFF0 + 20'(i));
        repeat (2) cyc();
        rst = 1'b1;
        repeat (12) cyc();
        @(negedge clk);
        check("rerst_count", 32'(q_count), 32'd6);
        check("rerst_ip",    32'(q_ip),    32'h0);
        check("rerst_data",  32'(q_data),  32'(rom_fn(20'hFFFF0)));

        check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
        check("byte_queue_drained", 32'(exp_byte.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
